led_uart_reporter: RTL and testbench

- Downstream consumer of the ALU's 8-bit LED output register. The ALU's `LED` instruction write strobe pushes the new LED value into this block.
- Values are buffered in a small FIFO and serialised as 8N1 UART frames on one TX pin, so a host terminal can trace program output.
- Sits beside FF_LEDS at the top level. It has no back-pressure to the ALU; values that do not fit are dropped and flagged.

---
 rtl/led_uart_reporter.sv | 155 +++++++++++++++
 tb/tb_led_uart_reporter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_uart_reporter.sv
// LED value reporter: buffers ALU LED writes in a small FIFO and sends each as a UART frame.
// Optional LED_UART_PARITY_EN adds an even-parity bit (8E1 instead of 8N1).

module led_uart_reporter #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 2
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iData,
   input  logic       iStrobe,
   output logic       oTx,
   output logic       oBusy,
   output logic       oFull,
   output logic       oOverflow
);

   // state  | meaning
   // IDLE   | line high, waiting for FIFO data
   // START  | start bit (low)
   // DATA   | 8 data bits, LSB first
   // PARITY | even parity bit (parity build only)
   // STOP   | stop bit (high), may chain straight into START

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int BW    = $clog2(CLKS_PER_BIT);

`ifdef LED_UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t             state, state_nxt;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [BW-1:0]      baud;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic               tx_q, tx_nxt;
   logic               ovf_q;
   logic               pop, push, drop;
   logic               fifo_empty, fifo_full, baud_wrap;
`ifdef LED_UART_PARITY_EN
   logic               parity_bit;
`endif

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
   assign baud_wrap  = (baud == BW'(CLKS_PER_BIT - 1));

   // A full FIFO still accepts a strobe when the FSM frees a slot that same cycle.
   assign push = iStrobe && (!fifo_full || pop);
   assign drop = iStrobe && fifo_full && !pop;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tx_nxt    = 1'b1;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx_nxt = 1'b0;
            if (baud_wrap) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shift[0];
            if (baud_wrap && bit_idx == 3'd7) begin
`ifdef LED_UART_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef LED_UART_PARITY_EN
         PARITY: begin
            tx_nxt = parity_bit;
            if (baud_wrap) state_nxt = STOP;
         end
`endif
         STOP: begin
            tx_nxt = 1'b1;
            if (baud_wrap) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Storage has no reset; pointers and count define what is valid.
   always_ff @(posedge Clock) begin
      if (push) mem[wr_ptr] <= iData;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
`ifdef LED_UART_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         tx_q  <= tx_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            shift  <= mem[rd_ptr];
`ifdef LED_UART_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (drop) ovf_q <= 1'b1;

         if (state == IDLE || baud_wrap) baud <= '0;
         else                            baud <= baud + 1'b1;

         if (state == START) begin
            bit_idx <= '0;
         end else if (state == DATA && baud_wrap) begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= {1'b0, shift[7:1]};
         end
      end
   end

   assign oTx       = tx_q;
   assign oBusy     = (state != IDLE) || !fifo_empty;
   assign oFull     = fifo_full;
   assign oOverflow = ovf_q;

endmodule

// File: tb/tb_led_uart_reporter.sv
// Scoreboard bench for led_uart_reporter: stimulus queues expected bytes, a UART
// monitor decodes oTx frames and compares them in order.

module tb_led_uart_reporter;

   localparam int CPB = 4;
`ifdef LED_UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME  = CPB * NB;
   localparam int MID    = CPB / 2;
   localparam int STOP_T = MID + CPB * (NB - 1);

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] iData = '0;
   logic       iStrobe = 1'b0;
   logic       oTx, oBusy, oFull, oOverflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];

   led_uart_reporter #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .Clock(Clock), .Reset(Reset), .iData(iData), .iStrobe(iStrobe),
      .oTx(oTx), .oBusy(oBusy), .oFull(oFull), .oOverflow(oOverflow)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // UART monitor: samples at mid-bit on the falling clock edge.
   int         mon_t = 0;
   logic       mon_active = 1'b0;
   logic       prev_tx = 1'b1;
   logic [7:0] mon_byte = '0;
   logic       mon_par = 1'b0;
   logic [7:0] mon_exp;

   always @(negedge Clock) begin
      if (Reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (prev_tx === 1'b1 && oTx === 1'b0) begin
            mon_active = 1'b1;
            mon_t = 0;
            start_q.push_back(cyc);
         end
      end else begin
         mon_t = mon_t + 1;
         if (mon_t == MID) chk("start_bit", {31'b0, oTx}, 32'd0);
         else if (mon_t >= MID + CPB && mon_t <= MID + 8 * CPB && (mon_t - MID) % CPB == 0)
            mon_byte = {oTx, mon_byte[7:1]};
         else if (NB == 11 && mon_t == MID + 9 * CPB) mon_par = oTx;
         if (mon_t == STOP_T) begin
            chk("stop_bit", {31'b0, oTx}, 32'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", {24'b0, mon_byte}, 32'hFFFF_FFFF);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("payload", {24'b0, mon_byte}, {24'b0, mon_exp});
               if (NB == 11) chk("parity_bit", {31'b0, mon_par}, {31'b0, ^mon_exp});
            end
            mon_active = 1'b0;
         end
      end
      prev_tx = oTx;
   end

   task automatic tick();
      @(negedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      iStrobe = 1'b0;
      repeat (2) tick();
      Reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while (oBusy && n < limit) begin
         tick();
         n++;
      end
      if (oBusy) chk({name, "_timeout"}, 32'd1, 32'd0);
      repeat (3) tick();
   endtask

   int c0, sq, n;
   logic [7:0] vals[6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and single 0xA5 frame
      do_reset();
      chk("rst_tx", {31'b0, oTx}, 32'd1);
      chk("rst_busy", {31'b0, oBusy}, 32'd0);
      chk("rst_full", {31'b0, oFull}, 32'd0);
      chk("rst_ovf", {31'b0, oOverflow}, 32'd0);
      sq = start_q.size();
      iData = 8'hA5; iStrobe = 1'b1; exp_q.push_back(8'hA5);
      tick();
      iStrobe = 1'b0; c0 = cyc;
      tick(); chk("tx_high_after_e1", {31'b0, oTx}, 32'd1);
      tick(); chk("tx_low_after_e2", {31'b0, oTx}, 32'd0);
      n = 0;
      while (oBusy && n < 500) begin tick(); n++; end
      // busy rises at the strobe edge and falls FRAME+1 edges later
      chk("busy_len", cyc - c0, FRAME + 1);
      repeat (3) tick();
      chk("a5_one_frame", start_q.size(), sq + 1);
      if (start_q.size() > sq) chk("a5_start_latency", start_q[sq] - c0, 2);
      chk("a5_drained", exp_q.size(), 0);

      // Three back-to-back frames
      sq = start_q.size();
      for (int i = 0; i < 3; i++) begin
         iData = 8'(i + 1); iStrobe = 1'b1; exp_q.push_back(8'(i + 1));
         tick();
      end
      iStrobe = 1'b0;
      wait_idle("b2b", 1000);
      chk("b2b_frames", start_q.size(), sq + 3);
      if (start_q.size() >= sq + 3) begin
         chk("b2b_gap1", start_q[sq + 1] - start_q[sq], FRAME);
         chk("b2b_gap2", start_q[sq + 2] - start_q[sq + 1], FRAME);
      end
      chk("b2b_drained", exp_q.size(), 0);

      // Six strobes: one popped, four buffered, sixth dropped
      for (int i = 0; i < 6; i++) begin
         iData = vals[i]; iStrobe = 1'b1;
         if (i < 5) exp_q.push_back(vals[i]);
         tick();
         if (i == 4) chk("full_after_5", {31'b0, oFull}, 32'd1);
         if (i == 4) chk("no_ovf_yet", {31'b0, oOverflow}, 32'd0);
      end
      iStrobe = 1'b0;
      chk("ovf_set", {31'b0, oOverflow}, 32'd1);
      chk("still_full", {31'b0, oFull}, 32'd1);
      wait_idle("ovf", 2000);
      chk("ovf_sticky", {31'b0, oOverflow}, 32'd1);
      chk("ovf_full_clear", {31'b0, oFull}, 32'd0);
      chk("ovf_drained", exp_q.size(), 0);

      // Full FIFO, strobe coincides with STOP->START pop
      do_reset();
      chk("rst2_ovf", {31'b0, oOverflow}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         iData = 8'h20 + 8'(i); iStrobe = 1'b1; exp_q.push_back(8'h20 + 8'(i));
         tick();
         if (i == 0) c0 = cyc;
      end
      iStrobe = 1'b0;
      chk("full_before_pop", {31'b0, oFull}, 32'd1);
      n = 0;
      while (cyc < c0 + FRAME && n < 500) begin tick(); n++; end
      chk("pre_pop_full", {31'b0, oFull}, 32'd1);
      iData = 8'h26; iStrobe = 1'b1; exp_q.push_back(8'h26);
      tick();
      iStrobe = 1'b0;
      chk("pushpop_ovf", {31'b0, oOverflow}, 32'd0);
      chk("pushpop_full", {31'b0, oFull}, 32'd1);
      wait_idle("pushpop", 2000);
      chk("pushpop_ovf_end", {31'b0, oOverflow}, 32'd0);
      chk("pushpop_drained", exp_q.size(), 0);

      // Reset mid-DATA of 0xFF with two entries queued
      do_reset();
      for (int i = 0; i < 3; i++) begin
         iData = (i == 0) ? 8'hFF : 8'h30 + 8'(i); iStrobe = 1'b1;
         tick();
         if (i == 0) c0 = cyc;
      end
      iStrobe = 1'b0;
      n = 0;
      while (cyc < c0 + 14 && n < 100) begin tick(); n++; end
      chk("mid_busy", {31'b0, oBusy}, 32'd1);
      Reset = 1'b1;
      tick();
      chk("mid_rst_tx", {31'b0, oTx}, 32'd1);
      chk("mid_rst_busy", {31'b0, oBusy}, 32'd0);
      chk("mid_rst_full", {31'b0, oFull}, 32'd0);
      Reset = 1'b0;
      sq = start_q.size();
      repeat (150) tick();
      chk("no_frames_after_rst", start_q.size(), sq);
      chk("idle_tx_after_rst", {31'b0, oTx}, 32'd1);

`ifdef LED_UART_PARITY_EN
      // 0x07 has three ones: parity bit 1, 44-cycle frame
      do_reset();
      sq = start_q.size();
      iData = 8'h07; iStrobe = 1'b1; exp_q.push_back(8'h07);
      tick();
      iStrobe = 1'b0; c0 = cyc;
      n = 0;
      while (cyc < c0 + 2 + MID + 9 * CPB && n < 200) begin tick(); n++; end
      chk("par07_bit", {31'b0, oTx}, 32'd1);
      n = 0;
      while (oBusy && n < 500) begin tick(); n++; end
      chk("par07_busy_len", cyc - c0, 45);
      repeat (3) tick();
      chk("par07_drained", exp_q.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
